// File: rtl/child_stage_controller_pkg.sv
// Shared definitions for the child stage controller.
// Holds the global stage width and encodings seen by the local PEs and the
// parent, plus small constant helpers used to size the reduction tree and
// the internal counters.
package child_stage_controller_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;

    typedef enum logic [STAGE_WIDTH-1:0] {
        ST_IDLE         = STAGE_IDLE,
        ST_LOADING      = STAGE_MEASUREMENT_LOADING,
        ST_GROW         = STAGE_GROW,
        ST_MERGE        = STAGE_MERGE,
        ST_PEELING      = STAGE_PEELING,
        ST_RESULT_VALID = STAGE_RESULT_VALID
    } stage_t;

    // Number of signals entering reduction level s when every earlier level
    // collapses groups of fanin bits into one.
    function automatic int or_level_width(input int width, input int fanin, input int s);
        int w;
        w = width;
        for (int i = 0; i < s; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    // Bits needed to hold the unsigned value (at least one).
    function automatic int width_for(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/child_stage_controller_or_reduce_pipe.sv
// or_reduce_pipe: registered OR reduction tree.
// Reduces WIDTH input flags to a single flag with exactly STAGES register
// levels of latency. Each level ORs groups of FANIN bits, zero-padding the
// last group; the final level ORs whatever remains so the output is always
// one bit even when STAGES is smaller than the natural tree depth.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset, clears every level
//   din    - per-PE flags
//   dout   - reduced flag, din delayed by STAGES cycles
module or_reduce_pipe
    import child_stage_controller_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int FANIN  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    for (genvar s = 0; s < STAGES; s++) begin : g_lvl
        localparam int W_IN  = or_level_width(WIDTH, FANIN, s);
        localparam int GROUP = (s == STAGES - 1) ? W_IN : FANIN;
        localparam int W_OUT = (W_IN + GROUP - 1) / GROUP;

        logic [W_IN-1:0]        d;
        logic [W_OUT*GROUP-1:0] padded;
        logic [W_OUT-1:0]       q;

        if (s == 0) begin : g_src
            assign d = din;
        end else begin : g_src
            assign d = g_lvl[s-1].q;
        end

        always_comb begin
            padded            = '0;
            padded[W_IN-1:0]  = d;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                q <= '0;
            end else begin
                for (int j = 0; j < W_OUT; j++) begin
                    q[j] <= |padded[j*GROUP +: GROUP];
                end
            end
        end
    end

    assign dout = g_lvl[STAGES-1].q[0];

endmodule

// File: rtl/child_stage_controller.sv
// child_stage_controller: global stage sequencer for one child FPGA of the
// multi-FPGA union-find decoder.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for the parent to raise decoding_start
// LOADING      | one cycle of measurement loading, counters restart
// GROW         | one cycle of cluster growth, counted as an iteration
// MERGE        | merging until busy has been quiet long enough, then obey
//              | the parent (stop -> PEELING, toggle -> GROW or limit)
// PEELING      | peeling for a minimum time, leave when next_iteration=1
// RESULT_VALID | one cycle, then IDLE with result_valid held high
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   busy_pe, odd_clusters_pe- per-PE flags, OR-reduced to the parent
//   decoding_start          - parent level: decode active / stop merging
//   next_iteration          - parent toggle in MERGE, level in PEELING
//   global_stage            - current stage encoding
//   result_valid            - decode complete, held until next start
//   iteration_counter       - GROW entries this decode (saturating)
//   cycle_counter           - decode latency in cycles (saturating)
//   iteration_limit_hit     - decode stopped on MAX_ITERATIONS
//   busy_to_parent          - reduced busy
//   odd_clusters_to_parent  - reduced odd-cluster flag
//   merge_done_to_parent    - local merge is quiescent
module child_stage_controller
    import child_stage_controller_pkg::*;
#(
    parameter int PU_COUNT                = 18,
    parameter int OR_FANIN                = 8,
    parameter int OR_TREE_STAGES          = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MAX_ITERATIONS          = 255,
    parameter int MERGE_MIN_DELAY         = 3,
    parameter int BUSY_QUIET_CYCLES       = 2,
    parameter int PEEL_MIN_DELAY          = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PU_COUNT-1:0]                busy_pe,
    input  logic [PU_COUNT-1:0]                odd_clusters_pe,
    input  logic                               decoding_start,
    input  logic                               next_iteration,
    output logic [STAGE_WIDTH-1:0]             global_stage,
    output logic                               result_valid,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [31:0]                        cycle_counter,
    output logic                               iteration_limit_hit,
    output logic                               busy_to_parent,
    output logic                               odd_clusters_to_parent,
    output logic                               merge_done_to_parent
);

    localparam int DELAY_MAX = (MERGE_MIN_DELAY > PEEL_MIN_DELAY) ? MERGE_MIN_DELAY : PEEL_MIN_DELAY;
    localparam int DELAY_W   = width_for(DELAY_MAX);
    localparam int QUIET_W   = width_for(BUSY_QUIET_CYCLES);
    localparam int ICW       = ITERATION_COUNTER_WIDTH;

    localparam logic [DELAY_W-1:0] DELAY_SAT   = DELAY_W'(DELAY_MAX);
    localparam logic [DELAY_W-1:0] MERGE_MIN_D = DELAY_W'(MERGE_MIN_DELAY);
    localparam logic [DELAY_W-1:0] PEEL_MIN_D  = DELAY_W'(PEEL_MIN_DELAY);
    localparam logic [QUIET_W-1:0] QUIET_SAT   = QUIET_W'(BUSY_QUIET_CYCLES);
    localparam logic [ICW-1:0]     ITER_MAX    = ICW'(MAX_ITERATIONS);

    stage_t               stage_q, stage_d;
    logic                 result_valid_q, result_valid_d;
    logic [ICW-1:0]       iter_q, iter_d;
    logic [31:0]          cyc_q, cyc_d;
    logic                 limit_q, limit_d;
    logic                 saved_q, saved_d;
    logic                 merge_done_q, merge_done_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [QUIET_W-1:0]   quiet_q, quiet_d;
    logic                 busy_red;
    logic                 odd_red;
    logic                 toggle;

    or_reduce_pipe #(
        .WIDTH  (PU_COUNT),
        .FANIN  (OR_FANIN),
        .STAGES (OR_TREE_STAGES)
    ) u_busy_reduce (
        .clk   (clk),
        .reset (reset),
        .din   (busy_pe),
        .dout  (busy_red)
    );

    or_reduce_pipe #(
        .WIDTH  (PU_COUNT),
        .FANIN  (OR_FANIN),
        .STAGES (OR_TREE_STAGES)
    ) u_odd_reduce (
        .clk   (clk),
        .reset (reset),
        .din   (odd_clusters_pe),
        .dout  (odd_red)
    );

    function automatic logic [ICW-1:0] iter_inc(input logic [ICW-1:0] v);
        return (v >= ITER_MAX) ? ITER_MAX : v + ICW'(1);
    endfunction

    // Comparing against the saved level rather than detecting an edge keeps
    // a toggle that lands before merge_done pending until it can be served.
    assign toggle = (next_iteration != saved_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            iter_q         <= '0;
            cyc_q          <= '0;
            limit_q        <= 1'b0;
            saved_q        <= 1'b0;
            merge_done_q   <= 1'b0;
            delay_q        <= '0;
            quiet_q        <= '0;
        end else begin
            stage_q        <= stage_d;
            result_valid_q <= result_valid_d;
            iter_q         <= iter_d;
            cyc_q          <= cyc_d;
            limit_q        <= limit_d;
            saved_q        <= saved_d;
            merge_done_q   <= merge_done_d;
            delay_q        <= delay_d;
            quiet_q        <= quiet_d;
        end
    end

    always_comb begin
        stage_d        = stage_q;
        result_valid_d = result_valid_q;
        iter_d         = iter_q;
        limit_d        = limit_q;
        saved_d        = saved_q;
        cyc_d          = cyc_q;
        delay_d        = delay_q;
        quiet_d        = quiet_q;
        merge_done_d   = 1'b0;

        if (stage_q != ST_IDLE && !result_valid_q && cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end

        case (stage_q)
            ST_IDLE: begin
                saved_d = 1'b0;
                if (decoding_start) begin
                    stage_d        = ST_LOADING;
                    result_valid_d = 1'b0;
                end
            end
            ST_LOADING: begin
                stage_d = ST_GROW;
                cyc_d   = 32'd1;
                iter_d  = iter_inc('0);
                limit_d = 1'b0;
            end
            ST_GROW: begin
                stage_d = ST_MERGE;
            end
            ST_MERGE: begin
                if (merge_done_q) begin
                    if (!decoding_start) begin
                        stage_d = ST_PEELING;
                    end else if (toggle) begin
                        saved_d = next_iteration;
                        if (iter_q == ITER_MAX) begin
                            stage_d = ST_PEELING;
                            limit_d = 1'b1;
                        end else begin
                            stage_d = ST_GROW;
                            iter_d  = iter_inc(iter_q);
                        end
                    end
                end
            end
            ST_PEELING: begin
                saved_d = 1'b0;
                if (delay_q >= PEEL_MIN_D && next_iteration) begin
                    stage_d = ST_RESULT_VALID;
                end
            end
            ST_RESULT_VALID: begin
                stage_d        = ST_IDLE;
                result_valid_d = 1'b1;
            end
            default: begin
                stage_d = ST_IDLE;
            end
        endcase

        // delay_counter restarts on every stage change, so it counts cycles
        // spent in the current MERGE or PEELING visit.
        if (stage_d != stage_q) begin
            delay_d = '0;
        end else if (delay_q != DELAY_SAT) begin
            delay_d = delay_q + DELAY_W'(1);
        end

        if (stage_d == ST_MERGE && stage_q != ST_MERGE) begin
            quiet_d = '0;
        end else if (stage_q == ST_MERGE) begin
            if (busy_red) begin
                quiet_d = '0;
            end else if (quiet_q != QUIET_SAT) begin
                quiet_d = quiet_q + QUIET_W'(1);
            end
        end

        // Registered from the next counter values so the flag lines up with
        // the counters it describes.
        if (stage_q == ST_MERGE && stage_d == ST_MERGE) begin
            merge_done_d = (delay_d >= MERGE_MIN_D) && (quiet_d >= QUIET_SAT);
        end
    end

    assign global_stage           = stage_q;
    assign result_valid           = result_valid_q;
    assign iteration_counter      = iter_q;
    assign cycle_counter          = cyc_q;
    assign iteration_limit_hit    = limit_q;
    assign busy_to_parent         = busy_red;
    assign odd_clusters_to_parent = odd_red;
    assign merge_done_to_parent   = merge_done_q;

endmodule

// File: tb/tb_child_stage_controller.sv
// Testbench for child_stage_controller: directed scenarios followed by
// randomized parent/PE activity, every cycle compared with a behavioural
// model of the stage rules.
module tb_child_stage_controller;

    localparam int PU      = 18;
    localparam int FANIN   = 8;
    localparam int STAGES  = 2;
    localparam int ICW     = 8;
    localparam int MAXIT   = 3;
    localparam int MMIN    = 3;
    localparam int QUIET   = 2;
    localparam int PMIN    = 3;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_GROW  = 2;
    localparam int S_MERGE = 3;
    localparam int S_PEEL  = 4;
    localparam int S_RV    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [PU-1:0]   busy_pe;
    logic [PU-1:0]   odd_clusters_pe;
    logic            decoding_start;
    logic            next_iteration;
    logic [2:0]      global_stage;
    logic            result_valid;
    logic [ICW-1:0]  iteration_counter;
    logic [31:0]     cycle_counter;
    logic            iteration_limit_hit;
    logic            busy_to_parent;
    logic            odd_clusters_to_parent;
    logic            merge_done_to_parent;

    always #5 clk = ~clk;

    child_stage_controller #(
        .PU_COUNT                (PU),
        .OR_FANIN                (FANIN),
        .OR_TREE_STAGES          (STAGES),
        .ITERATION_COUNTER_WIDTH (ICW),
        .MAX_ITERATIONS          (MAXIT),
        .MERGE_MIN_DELAY         (MMIN),
        .BUSY_QUIET_CYCLES       (QUIET),
        .PEEL_MIN_DELAY          (PMIN)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .busy_pe                (busy_pe),
        .odd_clusters_pe        (odd_clusters_pe),
        .decoding_start         (decoding_start),
        .next_iteration         (next_iteration),
        .global_stage           (global_stage),
        .result_valid           (result_valid),
        .iteration_counter      (iteration_counter),
        .cycle_counter          (cycle_counter),
        .iteration_limit_hit    (iteration_limit_hit),
        .busy_to_parent         (busy_to_parent),
        .odd_clusters_to_parent (odd_clusters_to_parent),
        .merge_done_to_parent   (merge_done_to_parent)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc_no, obs, exp);
        end
    endtask

    // Behavioural model: unbounded integer counters, reduction modelled as a
    // pure STAGES-cycle delay of the OR of all inputs.
    int     m_stage;
    bit     m_rv, m_lim, m_md, m_saved;
    int     m_iter;
    longint m_cyc;
    int     m_delay, m_quiet;
    bit     b_hist [STAGES];
    bit     o_hist [STAGES];

    task automatic model_update(input bit r, input bit ds, input bit ni,
                                input logic [PU-1:0] bz, input logic [PU-1:0] od);
        bit bt;
        int nxt;
        bt = b_hist[STAGES-1];
        for (int i = STAGES - 1; i > 0; i--) begin
            b_hist[i] = b_hist[i-1];
            o_hist[i] = o_hist[i-1];
        end
        b_hist[0] = !r && (bz != 0);
        o_hist[0] = !r && (od != 0);
        if (r) begin
            m_stage = S_IDLE; m_rv = 0; m_lim = 0; m_md = 0; m_saved = 0;
            m_iter = 0; m_cyc = 0; m_delay = 0; m_quiet = 0;
            for (int i = 0; i < STAGES; i++) begin
                b_hist[i] = 0;
                o_hist[i] = 0;
            end
            return;
        end
        if (m_stage == S_LOAD) m_cyc = 1;
        else if (m_stage != S_IDLE && !m_rv && m_cyc < 64'hFFFF_FFFF) m_cyc++;
        case (m_stage)
            S_IDLE: begin
                m_saved = 0;
                if (ds) begin m_stage = S_LOAD; m_rv = 0; end
            end
            S_LOAD: begin
                m_stage = S_GROW; m_iter = 1; m_lim = 0;
            end
            S_GROW: begin
                m_stage = S_MERGE; m_delay = 0; m_quiet = 0; m_md = 0;
            end
            S_MERGE: begin
                nxt = S_MERGE;
                if (m_md) begin
                    if (!ds) nxt = S_PEEL;
                    else if (ni != m_saved) begin
                        m_saved = ni;
                        if (m_iter == MAXIT) begin nxt = S_PEEL; m_lim = 1; end
                        else begin nxt = S_GROW; m_iter++; end
                    end
                end
                if (nxt == S_MERGE) begin
                    m_delay++;
                    m_quiet = bt ? 0 : m_quiet + 1;
                    m_md = (m_delay >= MMIN) && (m_quiet >= QUIET);
                end else begin
                    m_md = 0; m_delay = 0;
                end
                m_stage = nxt;
            end
            S_PEEL: begin
                m_saved = 0;
                if (m_delay >= PMIN && ni) begin m_stage = S_RV; m_delay = 0; end
                else m_delay++;
            end
            S_RV: begin
                m_stage = S_IDLE; m_rv = 1;
            end
            default: m_stage = S_IDLE;
        endcase
    endtask

    task automatic compare_outputs();
        check_eq("global_stage", 64'(global_stage), 64'(m_stage));
        check_eq("result_valid", 64'(result_valid), 64'(m_rv));
        check_eq("iteration_counter", 64'(iteration_counter), 64'(m_iter));
        check_eq("cycle_counter", 64'(cycle_counter), 64'(m_cyc));
        check_eq("iteration_limit_hit", 64'(iteration_limit_hit), 64'(m_lim));
        check_eq("busy_to_parent", 64'(busy_to_parent), 64'(b_hist[STAGES-1]));
        check_eq("odd_clusters_to_parent", 64'(odd_clusters_to_parent), 64'(o_hist[STAGES-1]));
        check_eq("merge_done_to_parent", 64'(merge_done_to_parent), 64'(m_md));
    endtask

    task automatic step(input bit r, input bit ds, input bit ni,
                        input logic [PU-1:0] bz, input logic [PU-1:0] od);
        @(negedge clk);
        compare_outputs();
        reset           = r;
        decoding_start  = ds;
        next_iteration  = ni;
        busy_pe         = bz;
        odd_clusters_pe = od;
        model_update(r, ds, ni, bz, od);
        cyc_no++;
    endtask

    logic [PU-1:0] z;
    logic [PU-1:0] bit5;
    logic [PU-1:0] last_bit;
    logic [PU-1:0] all_ones;

    initial begin
        bit ni_cur;
        bit ds;
        bit r;
        int burst;
        logic [PU-1:0] bz;
        logic [PU-1:0] od;

        z = '0; bit5 = '0; bit5[5] = 1'b1;
        last_bit = '0; last_bit[PU-1] = 1'b1;
        all_ones = '1;

        reset = 1'b1; decoding_start = 1'b0; next_iteration = 1'b0;
        busy_pe = '0; odd_clusters_pe = '0;
        model_update(1, 0, 0, z, z);

        // Reset, then start: IDLE, LOADING, GROW, MERGE.
        for (int i = 0; i < 2; i++) step(1, 0, 0, z, z);
        for (int i = 0; i < 4; i++) step(0, 1, 0, z, z);

        // Busy on PE 5 for 10 MERGE cycles with an early toggle, then quiet.
        for (int i = 0; i < 10; i++) step(0, 1, 1, bit5, z);
        for (int i = 0; i < 10; i++) step(0, 1, 1, z, z);

        // Stop with a simultaneous toggle: stop wins, then peel and finish.
        step(0, 0, 0, z, z);
        for (int i = 0; i < 3; i++) step(0, 0, 0, z, z);
        for (int i = 0; i < 4; i++) step(0, 0, 1, z, z);
        for (int i = 0; i < 3; i++) step(0, 0, 0, z, z);

        // Odd-cluster pulse on the last PE.
        step(0, 0, 0, z, last_bit);
        for (int i = 0; i < 4; i++) step(0, 0, 0, z, z);

        // Parent toggles every cycle until the iteration limit ends MERGE.
        ni_cur = 0;
        step(0, 1, ni_cur, z, z);
        for (int i = 0; i < 40; i++) begin
            ni_cur = ~ni_cur;
            step(0, 1, ni_cur, z, z);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, z, z);

        // Reset while in MERGE with busy high.
        for (int i = 0; i < 6; i++) step(0, 1, 0, all_ones, all_ones);
        step(1, 1, 0, all_ones, all_ones);
        for (int i = 0; i < 3; i++) step(0, 0, 0, z, z);

        // Randomized parent and PE activity.
        burst = 0;
        ni_cur = 0;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 499) == 0);
            case (m_stage)
                S_IDLE:  ds = ($urandom_range(0, 3) == 0);
                S_MERGE: ds = ($urandom_range(0, 24) != 0);
                default: ds = 1'($urandom_range(0, 1));
            endcase
            if (m_stage == S_PEEL) ni_cur = ($urandom_range(0, 2) == 0);
            else if (m_stage == S_MERGE) begin
                if ($urandom_range(0, 4) == 0) ni_cur = ~ni_cur;
            end else if ($urandom_range(0, 3) == 0) ni_cur = ~ni_cur;
            bz = '0;
            if (burst > 0) begin
                bz[$urandom_range(0, PU - 1)] = 1'b1;
                burst--;
            end else if ($urandom_range(0, 11) == 0) begin
                burst = $urandom_range(1, 12);
            end
            od = '0;
            if ($urandom_range(0, 5) == 0) od[$urandom_range(0, PU - 1)] = 1'b1;
            step(r, ds, ni_cur, bz, od);
        end
        @(negedge clk);
        compare_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
